muldiv_sequencer: RTL and testbench

- Iterative RV32M multiply/divide engine and its sequencing FSM, attached to the EX stage beside the ALU.
- Accepts one operation at a time from EX, using operands after forwarding.
- Raises a stall request to the hazard unit while the operation runs.
- Returns one result word with a one-cycle done pulse; EX muxes it into aluresult.
- A flush from the hazard unit aborts an operation in flight.

---
 rtl/riscv_defines.sv | 37 +++
 rtl/muldiv_sign_fix.sv | 33 +++
 rtl/muldiv_sequencer.sv | 177 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// Shared definitions for the EX-stage multiply/divide sequencer:
// operation encoding (funct3), FSM state encoding, iteration count,
// special-case result constants and operand-sign helpers.
package riscv_defines;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } muldiv_op_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_DONE = 2'd2
   } muldiv_state_t;

   localparam int          MULDIV_ITER = 32;
   localparam logic [31:0] DIV_ZERO_Q  = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN     = 32'h8000_0000;

   // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
   function automatic logic op_signed_a(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   // rs2 is treated as signed by MULH, DIV and REM (MULHSU keeps it unsigned).
   function automatic logic op_signed_b(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Final result stage of the multiply/divide sequencer: applies the sign
// correction to the unsigned magnitude and selects the word the op returns.
// For multiplies the whole 64-bit product is negated; for divides the
// quotient (low word) and remainder (high word) are negated independently.
module muldiv_sign_fix
   import riscv_defines::*;
(
   input  logic [63:0] mag_i,
   input  logic        neg_i,
   input  logic [2:0]  op_i,
   output logic [31:0] res_o
);

   logic [63:0] prod_fix;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;

   assign prod_fix = neg_i ? (~mag_i + 64'd1) : mag_i;
   assign quot_fix = neg_i ? (~mag_i[31:0] + 32'd1) : mag_i[31:0];
   assign rem_fix  = neg_i ? (~mag_i[63:32] + 32'd1) : mag_i[63:32];

   // Pick low/high product word, quotient or remainder by operation.
   always_comb begin
      res_o = prod_fix[31:0];
      case (op_i)
         OP_MUL:                       res_o = prod_fix[31:0];
         OP_MULH, OP_MULHSU, OP_MULHU: res_o = prod_fix[63:32];
         OP_DIV, OP_DIVU:              res_o = quot_fix;
         default:                      res_o = rem_fix;
      endcase
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide engine with its sequencing FSM, sitting in
// EX beside the ALU. One operation at a time: 32 shift-add (multiply) or
// restoring (divide) steps, then a single DONE cycle with a done pulse.
// Divide-by-zero and signed overflow skip the iteration entirely.
// stall_req holds F/D/E while the op runs; flush_e aborts it.
//
// Handshake: EX raises req_valid with stable operands and keeps it high
// until the cycle in which done=1; that cycle belongs to the finishing
// instruction, so a new request is only accepted in the IDLE cycle after it.
//
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// 33x33 signed product at acceptance; divides are unaffected.
module muldiv_sequencer
   import riscv_defines::*;
#(
   parameter int XLEN = 32
)(
   input  logic            clk,
   input  logic            start,
   input  logic            req_valid,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic            flush_e,
   output logic            stall_req,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [1:0]      dbg_state
);

   localparam logic [1:0] ST_IDLE = MD_IDLE;
   localparam logic [1:0] ST_CALC = MD_CALC;
   localparam logic [1:0] ST_DONE = MD_DONE;
   localparam logic [4:0] LAST_CNT = 5'(MULDIV_ITER - 1);

   logic [1:0]  state_q, state_d;
   logic [4:0]  count_q, count_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] mcand_q, mcand_d;   // multiplicand or divisor magnitude
   logic [63:0] prod_q, prod_d;     // product, or {remainder, quotient}
   logic        neg_q, neg_d;
   logic [31:0] result_q, result_d;

   // Operand conditioning at acceptance
   logic        sgn_a, sgn_b, sa, sb, acc_neg;
   logic [31:0] abs_a, abs_b;

   assign sgn_a   = op_signed_a(req_op);
   assign sgn_b   = op_signed_b(req_op);
   assign sa      = sgn_a & in_a[31];
   assign sb      = sgn_b & in_b[31];
   assign abs_a   = sa ? (~in_a + 32'd1) : in_a;
   assign abs_b   = sb ? (~in_b + 32'd1) : in_b;
   assign acc_neg = (req_op == OP_REM) ? sa : (sa ^ sb);

`ifdef MULDIV_FAST_MUL_EN
   logic signed [65:0] fast_prod;
   assign fast_prod = $signed({sgn_a & in_a[31], in_a}) * $signed({sgn_b & in_b[31], in_b});
`endif

   // One shift-add multiply step on the product register
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   assign mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);
   assign mul_next = {mul_sum, prod_q[31:1]};

   // One restoring divide step: shift, trial subtract, set quotient bit
   logic [32:0] div_shift;
   logic        div_ge;
   logic [31:0] div_sub;
   logic [63:0] div_next;
   assign div_shift = {prod_q[63:32], prod_q[31]};
   assign div_ge    = div_shift >= {1'b0, mcand_q};
   assign div_sub   = div_shift[31:0] - mcand_q;
   assign div_next  = {(div_ge ? div_sub : div_shift[31:0]), prod_q[30:0], div_ge};

   logic [31:0] fix_res;

   muldiv_sign_fix u_sign_fix (
      .mag_i (prod_q),
      .neg_i (neg_q),
      .op_i  (op_q),
      .res_o (fix_res)
   );

   // Next-state logic: acceptance, iteration, completion, flush override
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      op_d     = op_q;
      mcand_d  = mcand_q;
      prod_d   = prod_q;
      neg_d    = neg_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && !flush_e) begin
               op_d    = req_op;
               neg_d   = acc_neg;
               count_d = 5'd0;
               mcand_d = abs_b;
               if (req_op[2]) begin
                  if (in_b == 32'd0) begin
                     prod_d  = {in_a, DIV_ZERO_Q};
                     neg_d   = 1'b0;
                     state_d = ST_DONE;
                  end else if (sgn_a && (in_a == INT_MIN) && (in_b == DIV_ZERO_Q)) begin
                     prod_d  = {32'd0, INT_MIN};
                     neg_d   = 1'b0;
                     state_d = ST_DONE;
                  end else begin
                     prod_d  = {32'd0, abs_a};
                     state_d = ST_CALC;
                  end
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  prod_d  = fast_prod[63:0];
                  neg_d   = 1'b0;
                  state_d = ST_DONE;
`else
                  prod_d  = {32'd0, abs_a};
                  state_d = ST_CALC;
`endif
               end
            end
         end
         ST_CALC: begin
            prod_d  = op_q[2] ? div_next : mul_next;
            count_d = count_q + 5'd1;
            if (count_q == LAST_CNT) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            result_d = fix_res;
            state_d  = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (flush_e) begin
         state_d  = ST_IDLE;
         count_d  = 5'd0;
         result_d = result_q;
      end
   end

   // State and datapath registers, asynchronously cleared by start=0
   always_ff @(posedge clk or negedge start) begin
      if (!start) begin
         state_q  <= ST_IDLE;
         count_q  <= 5'd0;
         op_q     <= 3'd0;
         mcand_q  <= 32'd0;
         prod_q   <= 64'd0;
         neg_q    <= 1'b0;
         result_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         op_q     <= op_d;
         mcand_q  <= mcand_d;
         prod_q   <= prod_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE) && !flush_e;
   assign result    = done ? fix_res : result_q;
   assign stall_req = req_valid & ~done & ~flush_e;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M cases with
// fixed expected values, special cases, flush, mid-operation reset,
// back-to-back requests and randomised ops checked against a reference model.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        start = 1'b0;
   logic        req_valid = 1'b0;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] in_a = 32'd0;
   logic [31:0] in_b = 32'd0;
   logic        flush_e = 1'b0;
   logic        stall_req, busy, done;
   logic [31:0] result;
   logic [1:0]  dbg_state;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif

   muldiv_sequencer dut (
      .clk       (clk),
      .start     (start),
      .req_valid (req_valid),
      .req_op    (req_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .flush_e   (flush_e),
      .stall_req (stall_req),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // Reference model of the RV32M result
   function automatic logic [31:0] model_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, ub;
      logic [63:0] p;
      int q;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ub = longint'({32'd0, b});
      case (op)
         3'd0: begin p = 64'(sa * sb); return p[31:0]; end
         3'd1: begin p = 64'(sa * sb); return p[63:32]; end
         3'd2: begin p = 64'(sa * ub); return p[63:32]; end
         3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            q = $signed(a) / $signed(b);
            return q;
         end
         3'd5: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            return a / b;
         end
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            q = $signed(a) % $signed(b);
            return q;
         end
         default: begin
            if (b == 32'd0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op[2]) begin
         if (b == 32'd0) return 1;
         if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
         return 33;
      end
      return MUL_LAT;
   endfunction

   // Driver + checker for one complete operation starting from IDLE
   task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int lat;
      logic stall_ok;
      logic [31:0] exp_r;
      exp_q.push_back(exp_res);
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = op; in_a = a; in_b = b;
      stall_ok = 1'b1;
      lat = 0;
      @(negedge clk);
      if (stall_req !== 1'b1 || done !== 1'b0) stall_ok = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = k;
            break;
         end
         if (stall_req !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
      end
      exp_r = exp_q.pop_front();
      n_vec++;
      if (lat != exp_lat) begin
         n_err++;
         $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, exp_lat);
      end
      n_vec++;
      if (!stall_ok) begin
         n_err++;
         $display("FAIL %s stall_window: stall_req/busy not held high before done (got 0, expected 1)", name);
      end
      if (lat != 0) begin
         n_vec++;
         if (result !== exp_r) begin
            n_err++;
            $display("FAIL %s result: got 0x%08h, expected 0x%08h", name, result, exp_r);
         end
         n_vec++;
         if (stall_req !== 1'b0) begin
            n_err++;
            $display("FAIL %s stall_in_done: got %b, expected 0", name, stall_req);
         end
         req_valid = 1'b0;
         @(negedge clk);
         n_vec++;
         if (result !== exp_r || done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s hold: result 0x%08h done %b busy %b, expected 0x%08h 0 0",
                     name, result, done, busy, exp_r);
         end
      end else begin
         req_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      #12;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || stall_req !== 1'b0 || dbg_state !== 2'd0) begin
         n_err++;
         $display("FAIL reset_ctrl: busy %b done %b stall %b state %0d, expected 0 0 0 0",
                  busy, done, stall_req, dbg_state);
      end
      n_vec++;
      if (result !== 32'd0) begin
         n_err++;
         $display("FAIL reset_result: got 0x%08h, expected 0x00000000", result);
      end
      @(negedge clk);
      start = 1'b1;
   endtask

   task automatic test_mul();
      do_op("mul_7x-3", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
      do_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
      do_op("mulh_ff",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
      do_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
   endtask

   task automatic test_div();
      do_op("div_-7/2",  3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      do_op("rem_-7/2",  3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      do_op("divu_100/7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
      do_op("remu_100/7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
   endtask

   task automatic test_special();
      do_op("divu_5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      do_op("rem_5/0",  3'd6, 32'd5, 32'd0, 32'd5, 1);
      do_op("div_ovf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      do_op("rem_ovf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
   endtask

   task automatic test_flush();
      int seen;
      do_op("divu_pre", 3'd5, 32'd100, 32'd7, 32'd14, 33);
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 3'd4; in_a = 32'hFFFF_FFF9; in_b = 32'd2;
      repeat (10) @(posedge clk);
      #1;
      flush_e = 1'b1;
      @(negedge clk);
      n_vec++;
      if (stall_req !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL flush_cycle: stall %b done %b busy %b, expected 0 0 1", stall_req, done, busy);
      end
      @(posedge clk); #1;
      flush_e = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || dbg_state !== 2'd0 || result !== 32'd14) begin
         n_err++;
         $display("FAIL flush_idle: busy %b state %0d result 0x%08h, expected 0 0 0x0000000e",
                  busy, dbg_state, result);
      end
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      n_vec++;
      if (seen != 0) begin
         n_err++;
         $display("FAIL flush_no_done: got %0d done pulses, expected 0", seen);
      end
      do_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, MUL_LAT);
   endtask

   task automatic test_reset_mid_calc();
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 3'd5; in_a = 32'd1000; in_b = 32'd3;
      repeat (6) @(posedge clk);
      #1;
      start = 1'b0;
      #1;
      n_vec++;
      if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0 || dbg_state !== 2'd0) begin
         n_err++;
         $display("FAIL reset_mid_calc: busy %b done %b result 0x%08h state %0d, expected 0 0 0 0",
                  busy, done, result, dbg_state);
      end
      req_valid = 1'b0;
      @(negedge clk);
      start = 1'b1;
      do_op("divu_after_reset", 3'd5, 32'd1000, 32'd3, 32'd333, 33);
   endtask

   task automatic test_back_to_back();
      int pulses;
      int first_k;
      int gap;
      logic [31:0] exp_r;
      exp_q.push_back(32'd14);
      exp_q.push_back(32'd100);
      pulses = 0;
      first_k = 0;
      gap = 0;
      @(posedge clk); #1;
      req_valid = 1'b1; req_op = 3'd5; in_a = 32'd100; in_b = 32'd7;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            pulses++;
            if (exp_q.size() > 0) begin
               exp_r = exp_q.pop_front();
               n_vec++;
               if (result !== exp_r) begin
                  n_err++;
                  $display("FAIL b2b_result%0d: got 0x%08h, expected 0x%08h", pulses, result, exp_r);
               end
            end
            if (pulses == 1) begin
               first_k = k;
               in_a = 32'd1000; in_b = 32'd10;
            end else begin
               gap = k - first_k;
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      exp_q.delete();
      n_vec++;
      if (pulses != 2) begin
         n_err++;
         $display("FAIL b2b_pulses: got %0d done pulses, expected 2", pulses);
      end
      n_vec++;
      if (gap != 34) begin
         n_err++;
         $display("FAIL b2b_gap: got %0d cycles between done pulses, expected 34", gap);
      end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] a, b;
      for (int i = 0; i < 12; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom();
         case ($urandom_range(0, 3))
            0: b = 32'($urandom_range(1, 20));
            1: b = 32'd0;
            default: b = $urandom();
         endcase
         do_op($sformatf("rand%0d_op%0d", i, op), op, a, b, model_res(op, a, b), model_lat(op, a, b));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_flush();
      test_reset_mid_calc();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
